// File: rtl/polyvec_stream_tx.sv
`default_nettype none
// ============================================================================
// Module      : polyvec_stream_tx
// Description : Transmit side of the polyvec read-in interface. Holds one
//               polyvec (K polynomials x 2^DEPTH coefficients) in local
//               storage and, after start, streams it as coefficient pairs
//               tagged with index and k, paced by the consumer's readin_ok.
//               Pulses full_out once the last pair has been accepted.
// Options     : POLYVEC_STREAM_TX_REDUCE_EN - when defined, each coefficient
//               is conditionally reduced (v >= 3329 -> v - 3329) in the
//               output register stage; otherwise raw values are output.
// Revision    : 1.0 - initial release
// ============================================================================
module polyvec_stream_tx #(
    parameter int DEPTH = 8,
    parameter int K     = 4,
    parameter int DW    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [3:0]       wr_k,
    input  logic [DEPTH-1:0] wr_index,
    input  logic [DW-1:0]    wr_data,
    input  logic             start,
    input  logic             readin_ok,
    output logic             out_valid,
    output logic [DW-1:0]    dout_1,
    output logic [DW-1:0]    dout_2,
    output logic [DEPTH-1:0] out_index,
    output logic [3:0]       out_k,
    output logic             full_out,
    output logic             busy
);

    localparam int               c_NC       = 1 << DEPTH;
    localparam int               c_KW       = (K > 1) ? $clog2(K) : 1;
    localparam logic [DEPTH-1:0] c_LAST_IDX = DEPTH'(c_NC - 2);
    localparam logic [3:0]       c_LAST_K   = 4'(K - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD0  = 2'd1,
        S_STREAM = 2'd2,
        S_FULL   = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Coefficient storage; intentionally has no reset.
    logic [DW-1:0] r_mem [K][c_NC];

    logic             w_wr_ok;
    logic             w_accept;
    logic             w_wrap;
    logic             w_last;
    logic [DEPTH-1:0] w_nxt_idx;
    logic [3:0]       w_nxt_k;
    logic [c_KW-1:0]  w_rd_k;
    logic [DEPTH-1:0] w_rd_idx;
    logic [DEPTH-1:0] w_rd_idx_hi;
    logic [DW-1:0]    w_rd_lo;
    logic [DW-1:0]    w_rd_hi;

    // Conditional modular reduction applied on the way into the output register.
    function automatic logic [DW-1:0] f_out(input logic [DW-1:0] v);
`ifdef POLYVEC_STREAM_TX_REDUCE_EN
        if (32'(v) >= 32'd3329)
            return v - DW'(3329);
        else
            return v;
`else
        return v;
`endif
    endfunction

    assign w_wr_ok   = wr_en && (r_state == S_IDLE) && ({28'd0, wr_k} < 32'(K));
    assign w_accept  = out_valid && readin_ok;
    assign w_wrap    = (out_index == c_LAST_IDX);
    assign w_last    = w_wrap && (out_k == c_LAST_K);
    assign w_nxt_idx = out_index + DEPTH'(2);
    assign w_nxt_k   = w_wrap ? (out_k + 4'd1) : out_k;

    // LOAD0 always fetches the first pair; STREAM prefetches the pair after
    // the one currently presented so it can be registered with no bubble.
    assign w_rd_k      = (r_state == S_LOAD0) ? '0 : w_nxt_k[c_KW-1:0];
    assign w_rd_idx    = (r_state == S_LOAD0) ? '0 : w_nxt_idx;
    assign w_rd_idx_hi = {w_rd_idx[DEPTH-1:1], 1'b1};
    assign w_rd_lo     = r_mem[w_rd_k][w_rd_idx];
    assign w_rd_hi     = r_mem[w_rd_k][w_rd_idx_hi];

    assign full_out = (r_state == S_FULL);
    assign busy     = (r_state != S_IDLE);

    // Load port: writes land only while idle and for a valid polynomial.
    always_ff @(posedge clk) begin
        if (w_wr_ok)
            r_mem[wr_k[c_KW-1:0]][wr_index] <= wr_data;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_nxt = S_LOAD0;
            S_LOAD0:  w_state_nxt = S_STREAM;
            S_STREAM: if (w_accept && w_last) w_state_nxt = S_FULL;
            S_FULL:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Output pair register: holds the presented pair until it is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            dout_1    <= '0;
            dout_2    <= '0;
            out_index <= '0;
            out_k     <= '0;
        end else begin
            case (r_state)
                S_LOAD0: begin
                    out_valid <= 1'b1;
                    dout_1    <= f_out(w_rd_lo);
                    dout_2    <= f_out(w_rd_hi);
                    out_index <= '0;
                    out_k     <= '0;
                end
                S_STREAM: begin
                    if (w_accept) begin
                        if (w_last) begin
                            out_valid <= 1'b0;
                        end else begin
                            dout_1    <= f_out(w_rd_lo);
                            dout_2    <= f_out(w_rd_hi);
                            out_index <= w_nxt_idx;
                            out_k     <= w_nxt_k;
                        end
                    end
                end
                default: out_valid <= 1'b0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_polyvec_stream_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_polyvec_stream_tx
// Description : Self-checking bench for polyvec_stream_tx. Keeps a reference
//               copy of the polyvec and derives the expected pair sequence
//               directly from pair number p (k = p / pairs, idx = 2*(p%pairs)).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_polyvec_stream_tx;

    localparam int DEPTH = 8;
    localparam int K     = 4;
    localparam int DW    = 16;
    localparam int NC    = 1 << DEPTH;
    localparam int NP    = NC / 2;
    localparam int TOTAL = K * NP;

    logic             clk;
    logic             reset;
    logic             wr_en;
    logic [3:0]       wr_k;
    logic [DEPTH-1:0] wr_index;
    logic [DW-1:0]    wr_data;
    logic             start;
    logic             readin_ok;
    logic             out_valid;
    logic [DW-1:0]    dout_1;
    logic [DW-1:0]    dout_2;
    logic [DEPTH-1:0] out_index;
    logic [3:0]       out_k;
    logic             full_out;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] mem_model [K][NC];

    polyvec_stream_tx #(.DEPTH(DEPTH), .K(K), .DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_k      (wr_k),
        .wr_index  (wr_index),
        .wr_data   (wr_data),
        .start     (start),
        .readin_ok (readin_ok),
        .out_valid (out_valid),
        .dout_1    (dout_1),
        .dout_2    (dout_2),
        .out_index (out_index),
        .out_k     (out_k),
        .full_out  (full_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output value of a stored coefficient.
    function automatic logic [DW-1:0] ev(input logic [DW-1:0] v);
`ifdef POLYVEC_STREAM_TX_REDUCE_EN
        return (v >= 16'd3329) ? v - 16'd3329 : v;
`else
        return v;
`endif
    endfunction

    function automatic logic [63:0] snap();
        return {17'd0, out_valid, out_k, out_index, dout_1, dout_2, full_out, busy};
    endfunction

    function automatic logic [63:0] mk(input logic v, input int k, input int idx,
                                       input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                                       input logic f, input logic b);
        return {17'd0, v, 4'(k), 8'(idx), d1, d2, f, b};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int k, input int i, input logic [DW-1:0] d);
        wr_en    = 1'b1;
        wr_k     = 4'(k);
        wr_index = 8'(i);
        wr_data  = d;
        tick();
        wr_en = 1'b0;
        if (k < K) mem_model[k][i] = d;
    endtask

    // mode: 0 = readin_ok always high, 1 = toggling, 2 = random.
    // stall_p/stall_len: hold readin_ok low for stall_len cycles at pair stall_p.
    // abort_p: assert reset while pair abort_p is presented.
    // inject_p: write and start attempts while pair inject_p is presented.
    task automatic run_stream(input int mode, input int stall_p, input int stall_len,
                              input int abort_p, input int inject_p);
        int   p       = 0;
        int   cyc     = 0;
        int   stalled = 0;
        int   k;
        int   idx;
        logic ok;
        start = 1'b1;
        tick();
        start = 1'b0;
        wr_en = 1'b0;
        check("load0", {61'd0, out_valid, full_out, busy}, 64'd1);
        tick();
        while (p < TOTAL && cyc < 8 * TOTAL + 100) begin
            k   = p / NP;
            idx = (p % NP) * 2;
            case (mode)
                0:       ok = 1'b1;
                1:       ok = (cyc % 2 == 0);
                default: ok = 1'($urandom_range(0, 1));
            endcase
            if (p == stall_p && stalled < stall_len) begin
                ok = 1'b0;
                stalled++;
            end
            readin_ok = ok;
            check("stream", snap(), mk(1'b1, k, idx, ev(mem_model[k][idx]),
                                       ev(mem_model[k][idx+1]), 1'b0, 1'b1));
            if (p == abort_p) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                readin_ok = 1'b0;
                check("reset_mid", snap(), 64'd0);
                return;
            end
            if (p == inject_p) begin
                wr_en    = 1'b1;
                wr_k     = 4'd0;
                wr_index = 8'd0;
                wr_data  = 16'd5;
                start    = 1'b1;
            end
            tick();
            cyc++;
            wr_en = 1'b0;
            start = 1'b0;
            if (ok) p++;
        end
        if (p < TOTAL) check("timeout", 64'(p), 64'(TOTAL));
        readin_ok = 1'($urandom_range(0, 1));
        check("full", snap(), mk(1'b0, K-1, NC-2, ev(mem_model[K-1][NC-2]),
                                 ev(mem_model[K-1][NC-1]), 1'b1, 1'b1));
        tick();
        check("idle", snap(), mk(1'b0, K-1, NC-2, ev(mem_model[K-1][NC-2]),
                                 ev(mem_model[K-1][NC-1]), 1'b0, 1'b0));
        readin_ok = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        wr_en     = 1'b0;
        wr_k      = 4'd0;
        wr_index  = '0;
        wr_data   = '0;
        start     = 1'b0;
        readin_ok = 1'b0;
        repeat (3) tick();
        check("reset_state", snap(), 64'd0);
        reset = 1'b0;
        tick();
        check("idle_after_reset", snap(), 64'd0);

        // Ramp pattern, plus writes to nonexistent polynomials that must vanish.
        for (int k = 0; k < K; k++)
            for (int i = 0; i < NC; i++)
                wr(k, i, DW'(16 * k + i));
        for (int n = 0; n < 20; n++)
            wr(int'($urandom_range(K, 15)), int'($urandom_range(0, NC-1)), DW'($urandom));

        run_stream(0, -1, 0, -1, -1);        // continuous
        run_stream(1, -1, 0, -1, -1);        // toggling readin_ok
        run_stream(0, 255, 20, -1, -1);      // stall at k=1, idx=254
        run_stream(0, -1, 0, 306, -1);       // reset at k=2, idx=100
        run_stream(0, -1, 0, -1, -1);        // restart from the beginning
        run_stream(0, -1, 0, -1, 40);        // ignored write/start mid-stream
        run_stream(0, -1, 0, -1, -1);        // original mem[0][0] still present

        // Write and start in the same idle cycle: stream sees the new value.
        wr_en    = 1'b1;
        wr_k     = 4'd0;
        wr_index = 8'd0;
        wr_data  = 16'h1234;
        mem_model[0][0] = 16'h1234;
        run_stream(2, -1, 0, -1, -1);

        // Reduction boundary values.
        wr(0, 0, 16'd3329);
        wr(0, 1, 16'd3328);
        wr(0, 2, 16'd6000);
        wr(0, 3, 16'd7000);
        run_stream(2, -1, 0, -1, -1);

        // Random contents with random pacing.
        for (int k = 0; k < K; k++)
            for (int i = 0; i < NC; i++)
                wr(k, i, DW'($urandom));
        for (int n = 0; n < 20; n++)
            wr(int'($urandom_range(K, 15)), int'($urandom_range(0, NC-1)), DW'($urandom));
        run_stream(2, -1, 0, -1, -1);
        run_stream(2, int'($urandom_range(0, TOTAL-1)), 15, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
